// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory game: sequences the round/address counters,
// the play register and the comparator. The inactivity timeout exists only
// when UC_TIMEOUT_EN is defined.
module unidade_controle_jogo #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimRodadas,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       contaR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_GANHOU     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_PERDEU     = 4'hE
  } estado_t;

  estado_t estado, proximo;
  logic    timeout;

  if ((2 ** TW) < TIMEOUT_CYCLES) begin : g_tw_check
    $error("TW too narrow for TIMEOUT_CYCLES");
  end

`ifdef UC_TIMEOUT_EN
  logic [TW-1:0] cnt_timeout;
  localparam logic [TW-1:0] CNT_LIMITE = TW'(TIMEOUT_CYCLES - 1);

  // Counts only while waiting for a play; holds at the limit instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset || (estado != ESPERA))
      cnt_timeout <= '0;
    else if (cnt_timeout != CNT_LIMITE)
      cnt_timeout <= cnt_timeout + 1'b1;
  end

  assign timeout = (estado == ESPERA) && (cnt_timeout == CNT_LIMITE);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      estado <= INICIAL;
    else
      estado <= proximo;
  end

  always_comb begin
    proximo = INICIAL;
    unique case (estado)
      INICIAL:        proximo = iniciar ? PREPARA : INICIAL;
      PREPARA:        proximo = INICIA_RODADA;
      INICIA_RODADA:  proximo = ESPERA;
      // A play arriving in the timeout cycle still counts.
      ESPERA: begin
        if (jogada)       proximo = REGISTRA;
        else if (timeout) proximo = FIM_TIMEOUT;
        else              proximo = ESPERA;
      end
      REGISTRA:       proximo = COMPARA;
      COMPARA: begin
        if (!igual)                                proximo = FIM_PERDEU;
        else if (enderecoIgualRodada && fimRodadas) proximo = FIM_GANHOU;
        else if (enderecoIgualRodada)              proximo = PROXIMA_RODADA;
        else                                       proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA;
      PROXIMA_RODADA: proximo = INICIA_RODADA;
      FIM_GANHOU:     proximo = iniciar ? PREPARA : FIM_GANHOU;
      FIM_PERDEU:     proximo = iniciar ? PREPARA : FIM_PERDEU;
      FIM_TIMEOUT:    proximo = iniciar ? PREPARA : FIM_TIMEOUT;
      default:        proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraR      = 1'b0;
    contaR     = 1'b0;
    registraR  = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    unique case (estado)
      PREPARA: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      INICIA_RODADA:  zeraE     = 1'b1;
      REGISTRA:       registraR = 1'b1;
      PROXIMA_JOGADA: contaE    = 1'b1;
      PROXIMA_RODADA: contaR    = 1'b1;
      FIM_GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo: a vector table for the game flow
// plus hand sequences for reset-in-COMPARA and the timeout corner cases.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual, enderecoIgualRodada, fimRodadas;
  logic       zeraE, contaE, zeraR, contaR, registraR;
  logic       pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [8:0] O_ZE  = 9'b100000000;
  localparam logic [8:0] O_CE  = 9'b010000000;
  localparam logic [8:0] O_ZR  = 9'b001000000;
  localparam logic [8:0] O_CR  = 9'b000100000;
  localparam logic [8:0] O_REG = 9'b000010000;
  localparam logic [8:0] O_PRO = 9'b000001000;
  localparam logic [8:0] O_GAN = 9'b000000100;
  localparam logic [8:0] O_PER = 9'b000000010;
  localparam logic [8:0] O_TMO = 9'b000000001;

  typedef struct {
    logic       ini, jog, igu, eir, fim;
    logic [3:0] est;
    logic [8:0] outs;
  } vec_t;

  vec_t vecs[$];

  unidade_controle_jogo #(.TIMEOUT_CYCLES(20), .TW(5)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .enderecoIgualRodada(enderecoIgualRodada),
    .fimRodadas(fimRodadas), .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR),
    .contaR(contaR), .registraR(registraR), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] outs_now();
    return {zeraE, contaE, zeraR, contaR, registraR, pronto, ganhou, perdeu, db_timeout};
  endfunction

  task automatic add(input logic ini, jog, igu, eir, fim,
                     input logic [3:0] est, input logic [8:0] outs);
    vec_t v;
    v.ini = ini; v.jog = jog; v.igu = igu; v.eir = eir; v.fim = fim;
    v.est = est; v.outs = outs;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] est, input logic [8:0] outs);
    n_total++;
    if (db_estado === est && outs_now() === outs)
      n_pass++;
    else
      $display("FAIL %s: estado=%h outs=%b, expected estado=%h outs=%b",
               name, db_estado, outs_now(), est, outs);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ini, jog, igu, eir, fim);
    iniciar = ini; jogada = jog; igual = igu;
    enderecoIgualRodada = eir; fimRodadas = fim;
  endtask

  // Restart from a final state or INICIAL and land in ESPERA.
  task automatic go_espera();
    drive(1, 0, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); step(); step();
  endtask

  initial begin
    // idle
    for (int i = 0; i < 10; i++) add(0,0,0,0,0, 4'h0, 9'b0);
    // start; iniciar held, ignored once running
    add(1,0,0,0,0, 4'h1, O_ZE | O_ZR);
    add(1,0,0,0,0, 4'h2, O_ZE);
    add(1,0,0,0,0, 4'h3, 9'b0);
    add(1,0,0,0,0, 4'h3, 9'b0);
    add(1,0,0,0,0, 4'h3, 9'b0);
    add(0,0,0,0,0, 4'h3, 9'b0);
    // round 1: last address of the round, not the last round
    add(0,1,1,1,0, 4'h4, O_REG);
    add(0,0,1,1,0, 4'h5, 9'b0);
    add(0,0,1,1,0, 4'h7, O_CR);
    add(0,0,1,1,0, 4'h2, O_ZE);
    add(0,0,1,1,0, 4'h3, 9'b0);
    add(0,0,1,1,0, 4'h3, 9'b0);
    // round 2: correct non-final play, then a wrong one
    add(0,1,1,0,0, 4'h4, O_REG);
    add(0,0,1,0,0, 4'h5, 9'b0);
    add(0,0,1,0,0, 4'h6, O_CE);
    add(0,0,1,0,0, 4'h3, 9'b0);
    add(0,1,0,0,0, 4'h4, O_REG);
    add(0,0,0,1,1, 4'h5, 9'b0);
    add(0,0,0,1,1, 4'hE, O_PRO | O_PER);
    add(0,0,0,0,0, 4'hE, O_PRO | O_PER);
    // restart and win on the last round
    add(1,0,0,0,0, 4'h1, O_ZE | O_ZR);
    add(0,0,0,0,0, 4'h2, O_ZE);
    add(0,0,0,0,0, 4'h3, 9'b0);
    add(0,1,1,1,1, 4'h4, O_REG);
    add(0,0,1,1,1, 4'h5, 9'b0);
    add(0,0,1,1,1, 4'hA, O_PRO | O_GAN);
    add(0,0,0,0,0, 4'hA, O_PRO | O_GAN);
    add(1,0,0,0,0, 4'h1, O_ZE | O_ZR);
    add(0,0,0,0,0, 4'h2, O_ZE);
    add(0,0,0,0,0, 4'h3, 9'b0);

    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    step(); step();
    check("reset", 4'h0, 9'b0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ini, vecs[i].jog, vecs[i].igu, vecs[i].eir, vecs[i].fim);
      step();
      check($sformatf("vec%0d", i), vecs[i].est, vecs[i].outs);
    end

    // reset while in COMPARA
    drive(0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("reach_compara", 4'h5, 9'b0);
    reset = 1'b1; step();
    check("reset_in_compara", 4'h0, 9'b0);
    reset = 1'b0;

`ifdef UC_TIMEOUT_EN
    begin
      int n;
      go_espera();
      check("to_espera", 4'h3, 9'b0);
      n = 0;
      while (db_estado == 4'h3 && n < 100) begin
        step();
        n++;
      end
      n_total++;
      if (n == 20) n_pass++;
      else $display("FAIL timeout_cycles: got %0d, expected 20", n);
      check("timeout_state", 4'hD, O_PRO | O_PER | O_TMO);
      step();
      check("timeout_hold", 4'hD, O_PRO | O_PER | O_TMO);

      go_espera();
      repeat (19) step();
      check("espera_19", 4'h3, 9'b0);
      drive(0, 1, 1, 0, 0); step();
      check("jogada_beats_timeout", 4'h4, O_REG);
      drive(0, 0, 1, 0, 0); step();
      check("after_tie_compara", 4'h5, 9'b0);
      step(); step();
      check("counter_restarted", 4'h3, 9'b0);
      repeat (19) step();
      check("espera_again_19", 4'h3, 9'b0);
      step();
      check("timeout_again", 4'hD, O_PRO | O_PER | O_TMO);
    end
`else
    go_espera();
    check("to_espera", 4'h3, 9'b0);
    repeat (40) step();
    check("no_timeout", 4'h3, 9'b0);
    drive(0, 1, 1, 0, 0); step();
    check("late_jogada", 4'h4, O_REG);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
